instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Encodes symbolic instruction requests (op select, register fields, immediate) into 32-bit MIPS
//  words using the same opcode/funct table the main decoder consumes, and streams them with byte
//  addresses to the instruction-memory loader. Used by the self-test/program-load path.
//  The program is bracketed by start and in_last.
// PARAMETERS
//  ADDR_W     10   width of out_addr (byte address, wraps modulo 2^ADDR_W)
//  BASE_ADDR  0    address of first emitted word after start (multiple of 4)
//  MAX_WORDS  256  capacity in legal words per program (1..2^(ADDR_W-2))
//  ERR_W      8    width of err_count (saturating)
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-high reset
//  start      in   1       pulse: begin program (honoured only in IDLE or DONE)
//  in_valid   in   1       request valid
//  in_ready   out  1       request accepted when in_valid & in_ready
//  in_op      in   5       0 ADD,1 SUB,2 AND,3 OR,4 SLT,5 LW,6 SW,7 ADDI,8 ANDI,9 ORI,10 SLTI,
//                          11 BEQ,12 BNE,13 BGT,14 BGTE,15 BLE,16 BLEQ,17 J; 18..31 illegal
//  in_rs/in_rt/in_rd in 5 each  register fields
//  in_imm     in   26      imm16 = in_imm[15:0] (I-type/branch); target = in_imm[25:0] (J)
//  in_last    in   1       marks final request of program
//  out_valid  out  1       encoded word valid
//  out_ready  in   1       word consumed when out_valid & out_ready
//  out_instr  out  32      encoded instruction
//  out_addr   out  ADDR_W  byte address of out_instr
//  busy       out  1       state == RUN
//  done       out  1       level, state == DONE
//  full       out  1       capacity reached this program (sticky until start)
//  err        out  1       1-cycle pulse on accepted illegal op
//  err_count  out  ERR_W   saturating count of illegal ops (cleared by reset only)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; addr_cnt=BASE_ADDR; word_cnt=0.
//  FSM: IDLE -start-> RUN (addr_cnt<=BASE_ADDR, word_cnt<=0, full<=0). RUN -> DONE when
//   (last accepted or full) and output register empty/drained. DONE -start-> RUN. start in RUN ignored.
//  in_ready = RUN & !out_valid|out_ready & !last_seen & !full. Combinational on out_ready.
//  Encoding: R (ops 0-4): {6'h00,rs,rt,rd,5'd0,funct}, funct 20/22/24/25/2A.
//   I/branch (5-16): {opc,rs,rt,imm16}, opc 23,2B,08,0C,0D,0A,04,05,07,01,06,03. rd ignored.
//   J (17): {6'h02,target}. rs/rt/rd ignored.
//  Latency: accept at edge N -> out_valid, out_instr, out_addr valid after edge N (1 cycle).
//   Single output register; out_instr/out_addr held stable while out_valid & !out_ready.
//  Legal accept: out_addr<=addr_cnt; addr_cnt+=4 (wraps); word_cnt+=1; word_cnt==MAX_WORDS -> full=1.
//  Illegal accept: handshake completes; no word, addr/word_cnt unchanged; err=1 for 1 cycle;
//   err_count+=1 unless saturated. Illegal with in_last still ends the program.
//  Simultaneous output handshake and new accept in same cycle: register reloads, no bubble.
//  Async reset mid-program: word in flight discarded, out_valid=0 immediately, IDLE.
// TESTING
//  start; ADD rs=1 rt=2 rd=3 -> out_instr=0x00221820, out_addr=0x000, 1 cycle after accept.
//  LW rs=29 rt=8 imm=4 then ADDI rs=0 rt=9 imm=0xFFFF back-to-back, out_ready=1 ->
//   0x8FA80004 @0x000, 0x2009FFFF @0x004, no bubble.
//  J imm=0x0000010, in_last=1 -> 0x08000010; done=1 after drain; further in_valid not accepted.
//  out_ready=0 for 3 cycles with word pending -> in_ready=0, out_instr/out_addr stable.
//  in_op=25 -> no out_valid, err pulse, err_count=1, next legal word keeps prior address.
//  MAX_WORDS=2: 3 legal requests -> 2 words, full=1, 3rd never accepted, done=1.
//  Reset asserted while out_valid=1 -> out_valid=0 immediately, state IDLE.

Source files
------------

// File: rtl/instr_encoder.sv
// Encodes symbolic instruction requests into 32-bit MIPS words and streams them with byte
// addresses to the instruction-memory loader through a one-deep output register.
module instr_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 256,
    parameter int ERR_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [25:0]       in_imm,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              err,
    output logic [ERR_W-1:0]  err_count
);
    localparam int                WC_W   = $clog2(MAX_WORDS + 1);
    localparam logic [WC_W-1:0]   MAX_WC = WC_W'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(4);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic              last_seen;
    logic [ADDR_W-1:0] addr_cnt;
    logic [WC_W-1:0]   word_cnt;

    logic [5:0]  opc;
    logic [5:0]  funct;
    logic        legal;
    logic        is_r;
    logic        is_j;
    logic [31:0] enc_word;

    // Opcode/funct table shared with the main decoder.
    always_comb begin
        opc   = 6'h00;
        funct = 6'h00;
        legal = 1'b1;
        is_r  = 1'b0;
        is_j  = 1'b0;
        case (in_op)
            5'd0:    begin is_r = 1'b1; funct = 6'h20; end
            5'd1:    begin is_r = 1'b1; funct = 6'h22; end
            5'd2:    begin is_r = 1'b1; funct = 6'h24; end
            5'd3:    begin is_r = 1'b1; funct = 6'h25; end
            5'd4:    begin is_r = 1'b1; funct = 6'h2A; end
            5'd5:    opc = 6'h23;
            5'd6:    opc = 6'h2B;
            5'd7:    opc = 6'h08;
            5'd8:    opc = 6'h0C;
            5'd9:    opc = 6'h0D;
            5'd10:   opc = 6'h0A;
            5'd11:   opc = 6'h04;
            5'd12:   opc = 6'h05;
            5'd13:   opc = 6'h07;
            5'd14:   opc = 6'h01;
            5'd15:   opc = 6'h06;
            5'd16:   opc = 6'h03;
            5'd17:   begin is_j = 1'b1; opc = 6'h02; end
            default: legal = 1'b0;
        endcase
        if (is_r) begin
            enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, funct};
        end else if (is_j) begin
            enc_word = {opc, in_imm};
        end else begin
            enc_word = {opc, in_rs, in_rt, in_imm[15:0]};
        end
    end

    logic accept;
    logic load;
    logic out_valid_next;
    logic full_next;
    logic last_next;

    assign in_ready       = (state == RUN) && (!out_valid || out_ready) && !last_seen && !full;
    assign accept         = in_valid && in_ready;
    assign load           = accept && legal;
    assign out_valid_next = load || (out_valid && !out_ready);
    assign full_next      = full || (load && ((word_cnt + WC_W'(1)) == MAX_WC));
    assign last_next      = last_seen || (accept && in_last);

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            last_seen <= 1'b0;
            addr_cnt  <= BASE;
            word_cnt  <= '0;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= '0;
            full      <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= RUN;
                        addr_cnt  <= BASE;
                        word_cnt  <= '0;
                        full      <= 1'b0;
                        last_seen <= 1'b0;
                    end
                end
                RUN: begin
                    out_valid <= out_valid_next;
                    last_seen <= last_next;
                    full      <= full_next;
                    if (load) begin
                        out_instr <= enc_word;
                        out_addr  <= addr_cnt;
                        addr_cnt  <= addr_cnt + STEP;
                        word_cnt  <= word_cnt + WC_W'(1);
                    end
                    // Illegal ops complete the handshake but emit nothing.
                    if (accept && !legal) begin
                        err <= 1'b1;
                        if (err_count != '1) begin
                            err_count <= err_count + ERR_W'(1);
                        end
                    end
                    if ((last_next || full_next) && !out_valid_next) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a default instance plus a small wrapping/capacity instance.
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        reset;
    logic        start, in_valid, in_ready, in_last;
    logic [4:0]  in_op, in_rs, in_rt, in_rd;
    logic [25:0] in_imm;
    logic        out_valid, out_ready, busy, done, full, err;
    logic [31:0] out_instr;
    logic [9:0]  out_addr;
    logic [7:0]  err_count;

    logic        s_start, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic        s_busy, s_done, s_full, s_err;
    logic [31:0] s_out_instr;
    logic [3:0]  s_out_addr;
    logic [1:0]  s_err_count;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          accept_cyc = 0;
    int          exp_err = 0;
    logic [9:0]  exp_addr = '0;
    logic [3:0]  s_exp_addr = '0;
    logic [41:0] exp_q[$];
    logic [35:0] s_q[$];

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(10), .BASE_ADDR(0), .MAX_WORDS(256), .ERR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .busy(busy), .done(done), .full(full), .err(err),
        .err_count(err_count)
    );

    instr_encoder #(.ADDR_W(4), .BASE_ADDR(12), .MAX_WORDS(2), .ERR_W(2)) dut_small (
        .clk(clk), .reset(reset), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_last(in_last), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_instr(s_out_instr), .out_addr(s_out_addr), .busy(s_busy), .done(s_done),
        .full(s_full), .err(s_err), .err_count(s_err_count)
    );

    function automatic logic [31:0] ref_enc(input logic [4:0] op, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [4:0] rd,
                                            input logic [25:0] imm);
        logic [5:0] c;
        c = 6'h00;
        case (op)
            5'd0: c = 6'h20;  5'd1: c = 6'h22;  5'd2: c = 6'h24;  5'd3: c = 6'h25;
            5'd4: c = 6'h2A;  5'd5: c = 6'h23;  5'd6: c = 6'h2B;  5'd7: c = 6'h08;
            5'd8: c = 6'h0C;  5'd9: c = 6'h0D;  5'd10: c = 6'h0A; 5'd11: c = 6'h04;
            5'd12: c = 6'h05; 5'd13: c = 6'h07; 5'd14: c = 6'h01; 5'd15: c = 6'h06;
            5'd16: c = 6'h03; default: c = 6'h02;
        endcase
        if (op <= 5'd4) return {6'h00, rs, rt, rd, 5'd0, c};
        if (op <= 5'd16) return {c, rs, rt, imm[15:0]};
        return {c, imm};
    endfunction

    // Falling-edge sample point: every output handshake is scored here.
    task automatic step_neg();
        logic [41:0] e;
        logic [35:0] se;
        @(negedge clk);
        if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL word_extra: got instr=%08h addr=%03h, scoreboard empty", out_instr, out_addr);
            end else begin
                e = exp_q.pop_front();
                if ({out_instr, out_addr} !== e) begin
                    errors++;
                    $display("FAIL word: got instr=%08h addr=%03h, want instr=%08h addr=%03h",
                             out_instr, out_addr, e[41:10], e[9:0]);
                end else begin
                    $display("word instr=%08h addr=%03h ok", out_instr, out_addr);
                end
            end
        end
        if (s_out_valid && s_out_ready) begin
            checks++;
            if (s_q.size() == 0) begin
                errors++;
                $display("FAIL s_word_extra: got instr=%08h addr=%01h, scoreboard empty", s_out_instr, s_out_addr);
            end else begin
                se = s_q.pop_front();
                if ({s_out_instr, s_out_addr} !== se) begin
                    errors++;
                    $display("FAIL s_word: got instr=%08h addr=%01h, want instr=%08h addr=%01h",
                             s_out_instr, s_out_addr, se[35:4], se[3:0]);
                end else begin
                    $display("s_word instr=%08h addr=%01h ok", s_out_instr, s_out_addr);
                end
            end
        end
    endtask

    task automatic step_pos();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [25:0] imm, input logic last,
                        input logic legal);
        logic [31:0] w;
        logic [9:0]  a;
        bit          ok;
        w  = ref_enc(op, rs, rt, rd, imm);
        a  = exp_addr;
        ok = 1'b0;
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        for (int n = 0; n < 40 && !ok; n++) begin
            step_neg();
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                if (legal) begin
                    exp_q.push_back({w, a});
                    exp_addr = exp_addr + 10'd4;
                end
            end
            step_pos();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: op=%0d in_ready=%b after 40 cycles, want 1", op, in_ready);
        end else begin
            accept_cyc = cyc;
            checks++;
            if (out_valid !== legal || err !== !legal) begin
                errors++;
                $display("FAIL latency op=%0d: out_valid=%b err=%b, want %b %b", op, out_valid, err, legal, !legal);
            end
            if (legal) begin
                checks++;
                if (out_instr !== w || out_addr !== a) begin
                    errors++;
                    $display("FAIL out_reg op=%0d: got %08h@%03h, want %08h@%03h", op, out_instr, out_addr, w, a);
                end
            end else begin
                exp_err = exp_err + 1;
                checks++;
                if (err_count !== 8'(exp_err)) begin
                    errors++;
                    $display("FAIL err_count: got %0d, want %0d", err_count, exp_err);
                end
            end
        end
    endtask

    task automatic start_prog();
        start = 1'b1;
        step_neg();
        step_pos();
        start = 1'b0;
        exp_addr = 10'h000;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL start_busy: busy=%b, want 1", busy);
        end
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            step_neg();
            if (done === 1'b1) ok = 1'b1;
            else step_pos();
        end
        if (ok) step_pos();
        checks++;
        if (!ok || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_wait: done=%b busy=%b, want 1 0", done, busy);
        end
    endtask

    task automatic test_reset();
        step_neg();
        checks++;
        if ({out_valid, busy, done, full, err, in_ready} !== 6'b0 || err_count !== 8'd0 ||
            out_addr !== 10'd0 || out_instr !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: ov=%b busy=%b done=%b full=%b err=%b rdy=%b cnt=%0d addr=%03h instr=%08h, want all 0",
                     out_valid, busy, done, full, err, in_ready, err_count, out_addr, out_instr);
        end
        checks++;
        if ({s_out_valid, s_busy, s_done, s_full, s_err} !== 5'b0 || s_err_count !== 2'd0) begin
            errors++;
            $display("FAIL s_reset_state: ov=%b busy=%b done=%b full=%b err=%b cnt=%0d, want all 0",
                     s_out_valid, s_busy, s_done, s_full, s_err, s_err_count);
        end
        reset = 1'b0;
        step_pos();
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle: in_ready=%b busy=%b, want 0 0", in_ready, busy);
        end
    endtask

    task automatic test_add();
        start_prog();
        send(5'd0, 5'd1, 5'd2, 5'd3, 26'd0, 1'b1, 1'b1);
        checks++;
        if (out_instr !== 32'h00221820 || out_addr !== 10'h000) begin
            errors++;
            $display("FAIL add: got %08h@%03h, want 00221820@000", out_instr, out_addr);
        end
        wait_done();
    endtask

    task automatic test_back_to_back();
        int a1;
        start_prog();
        send(5'd5, 5'd29, 5'd8, 5'd0, 26'h4, 1'b0, 1'b1);
        a1 = accept_cyc;
        checks++;
        if (out_instr !== 32'h8FA80004) begin
            errors++;
            $display("FAIL lw: got %08h, want 8FA80004", out_instr);
        end
        send(5'd7, 5'd0, 5'd9, 5'd0, 26'hFFFF, 1'b0, 1'b1);
        checks++;
        if (out_instr !== 32'h2009FFFF || out_addr !== 10'h004 || accept_cyc - a1 !== 1) begin
            errors++;
            $display("FAIL addi_b2b: got %08h@%03h gap=%0d, want 2009FFFF@004 gap=1",
                     out_instr, out_addr, accept_cyc - a1);
        end
        send(5'd17, 5'd0, 5'd0, 5'd0, 26'h10, 1'b1, 1'b1);
        checks++;
        if (out_instr !== 32'h08000010) begin
            errors++;
            $display("FAIL j: got %08h, want 08000010", out_instr);
        end
        wait_done();
        in_op = 5'd0;
        in_valid = 1'b1;
        repeat (3) begin
            step_neg();
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL after_done: in_ready=%b out_valid=%b, want 0 0", in_ready, out_valid);
            end
            step_pos();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_stall();
        logic [31:0] w1;
        start_prog();
        out_ready = 1'b0;
        w1 = ref_enc(5'd0, 5'd4, 5'd5, 5'd6, 26'd0);
        send(5'd0, 5'd4, 5'd5, 5'd6, 26'd0, 1'b0, 1'b1);
        in_op = 5'd1; in_rs = 5'd7; in_rt = 5'd8; in_rd = 5'd9; in_last = 1'b1;
        in_valid = 1'b1;
        repeat (3) begin
            step_neg();
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== w1 || out_addr !== 10'h000) begin
                errors++;
                $display("FAIL stall: rdy=%b ov=%b got %08h@%03h, want 0 1 %08h@000",
                         in_ready, out_valid, out_instr, out_addr, w1);
            end
            step_pos();
        end
        out_ready = 1'b1;
        send(5'd1, 5'd7, 5'd8, 5'd9, 26'd0, 1'b1, 1'b1);
        wait_done();
    endtask

    task automatic test_illegal();
        start_prog();
        send(5'd25, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 1'b0);
        step_neg();
        step_pos();
        checks++;
        if (err !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse: err=%b out_valid=%b one cycle later, want 0 0", err, out_valid);
        end
        send(5'd9, 5'd3, 5'd4, 5'd0, 26'h1234, 1'b1, 1'b1);
        wait_done();
        start_prog();
        send(5'd31, 5'd0, 5'd0, 5'd0, 26'd0, 1'b1, 1'b0);
        wait_done();
    endtask

    task automatic test_ops();
        start_prog();
        for (int k = 0; k < 18; k++) begin
            send(5'(k), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 26'($urandom), (k == 17), 1'b1);
        end
        wait_done();
        checks++;
        if (full !== 1'b0) begin
            errors++;
            $display("FAIL full_early: full=%b after 18 words, want 0", full);
        end
    endtask

    task automatic s_send(input logic [4:0] op, input logic legal, input bit want_acc);
        logic [31:0] w;
        bit          ok;
        w  = ref_enc(op, 5'd1, 5'd2, 5'd3, 26'h0ABC);
        ok = 1'b0;
        in_op = op; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3; in_imm = 26'h0ABC; in_last = 1'b0;
        s_in_valid = 1'b1;
        for (int n = 0; n < 6 && !ok; n++) begin
            step_neg();
            if (s_in_ready === 1'b1) begin
                ok = 1'b1;
                if (legal) begin
                    s_q.push_back({w, s_exp_addr});
                    s_exp_addr = s_exp_addr + 4'd4;
                end
            end
            step_pos();
        end
        s_in_valid = 1'b0;
        checks++;
        if (ok != want_acc) begin
            errors++;
            $display("FAIL s_accept op=%0d: accepted=%0d, want %0d", op, ok, want_acc);
        end
        if (ok && !legal) begin
            checks++;
            if (s_err !== 1'b1) begin
                errors++;
                $display("FAIL s_err op=%0d: err=%b, want 1", op, s_err);
            end
        end
    endtask

    task automatic test_full();
        bit ok;
        s_out_ready = 1'b1;
        s_start = 1'b1;
        step_neg();
        step_pos();
        s_start = 1'b0;
        s_exp_addr = 4'hC;
        s_send(5'd18, 1'b0, 1'b1);
        s_send(5'd19, 1'b0, 1'b1);
        s_send(5'd20, 1'b0, 1'b1);
        s_send(5'd31, 1'b0, 1'b1);
        checks++;
        if (s_err_count !== 2'd3) begin
            errors++;
            $display("FAIL s_err_sat: err_count=%0d, want 3", s_err_count);
        end
        s_send(5'd0, 1'b1, 1'b1);
        s_send(5'd2, 1'b1, 1'b1);
        s_send(5'd3, 1'b1, 1'b0);
        ok = 1'b0;
        for (int n = 0; n < 10 && !ok; n++) begin
            step_neg();
            if (s_done === 1'b1) ok = 1'b1;
            else step_pos();
        end
        if (ok) step_pos();
        checks++;
        if (!ok || s_full !== 1'b1 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL s_full_done: done=%b full=%b busy=%b, want 1 1 0", s_done, s_full, s_busy);
        end
    endtask

    task automatic test_reset_mid();
        start_prog();
        out_ready = 1'b0;
        send(5'd0, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_addr !== 10'd0 || out_instr !== 32'd0 ||
            err_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid: ov=%b busy=%b addr=%03h instr=%08h cnt=%0d, want all 0",
                     out_valid, busy, out_addr, out_instr, err_count);
        end
        exp_q.delete();
        exp_err = 0;
        out_ready = 1'b1;
        step_neg();
        reset = 1'b0;
        step_pos();
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: rdy=%b busy=%b done=%b, want 0 0 0", in_ready, busy, done);
        end
        start_prog();
        send(5'd17, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF, 1'b1, 1'b1);
        wait_done();
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_last = 1'b0;
        in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
        s_start = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1;
        test_reset();
        test_add();
        test_back_to_back();
        test_stall();
        test_illegal();
        test_ops();
        test_full();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0 || s_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: %0d/%0d words never emitted, want 0/0", exp_q.size(), s_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
